a_bus_src_regs: RTL and testbench

- Upstream source stage for the A-bus OR-combiner.
- Holds eight 16-bit general registers (R0–R7) and one 16-bit immediate latch (IMM).
- Presents nine 16-bit gated outputs, drv0..drv8, wired one-to-one onto the A-bus combiner inputs in0..in8.
- Guarantees at most one output is non-zero per cycle, so the OR-bus carries exactly the selected source.

---
 rtl/a_bus_src_regs.sv | 125 ++++++++++++
 tb/tb_a_bus_src_regs.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/a_bus_src_regs.sv
// -----------------------------------------------------------------------------
// a_bus_src_regs
//
// Upstream source stage for the A-bus OR-combiner. Holds eight general
// registers (R0-R7) and one immediate latch (IMM). Each register drives its own
// gated output (drv0..drv8 -> combiner in0..in8). Only the source picked by
// a_sel is passed; all other outputs are forced to zero, so the OR-bus carries
// exactly the selected value.
//
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   rst_n     - synchronous active-low reset
//   wr_en     - register write strobe
//   wr_addr   - destination register index 0-7
//   wr_data   - register write data
//   imm_ld    - immediate latch load strobe
//   imm_data  - immediate value
//   a_sel     - A-bus source select: 0-7 = R0-R7, 8 = IMM, 9-15 = none
//   drv0..7   - gated R0..R7 toward A-bus in0..in7
//   drv8      - gated IMM toward A-bus in8
//   sel_err   - sticky flag, set after any cycle with a_sel in 9-15,
//               cleared only by reset
//
// Build option:
//   A_BUS_SRC_BYPASS_EN - when defined, a write or immediate load to the
//   currently selected source is forwarded combinationally to its output
//   (suppressed while rst_n is low). When undefined, the output shows the
//   stored (old) value until the edge after the write.
// -----------------------------------------------------------------------------
module a_bus_src_regs #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             imm_ld,
  input  logic [WIDTH-1:0] imm_data,
  input  logic [3:0]       a_sel,
  output logic [WIDTH-1:0] drv0,
  output logic [WIDTH-1:0] drv1,
  output logic [WIDTH-1:0] drv2,
  output logic [WIDTH-1:0] drv3,
  output logic [WIDTH-1:0] drv4,
  output logic [WIDTH-1:0] drv5,
  output logic [WIDTH-1:0] drv6,
  output logic [WIDTH-1:0] drv7,
  output logic [WIDTH-1:0] drv8,
  output logic             sel_err
);

  localparam logic [3:0] SEL_IMM = 4'd8;

  logic [WIDTH-1:0] regs_r [0:7];
  logic [WIDTH-1:0] imm_r;
  logic             sel_err_r;

  // Source value seen by each output gate (index 8 is the immediate).
  logic [WIDTH-1:0] src_s [0:8];
  logic [WIDTH-1:0] drv_s [0:8];
  logic             sel_bad_s;

  assign sel_bad_s = (a_sel > SEL_IMM);

  // Register file, immediate latch and sticky select-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= RESET_VAL;
      end
      imm_r     <= RESET_VAL;
      sel_err_r <= 1'b0;
    end else begin
      if (wr_en) begin
        regs_r[wr_addr] <= wr_data;
      end
      if (imm_ld) begin
        imm_r <= imm_data;
      end
      // Set-only: the flag can be cleared by reset alone.
      if (sel_bad_s) begin
        sel_err_r <= 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : g_reg_src
`ifdef A_BUS_SRC_BYPASS_EN
      // Write-through: a write to register g this cycle is shown immediately,
      // except in a reset cycle where the write is discarded.
      assign src_s[g] = (rst_n && wr_en && (wr_addr == 3'(g))) ? wr_data : regs_r[g];
`else
      assign src_s[g] = regs_r[g];
`endif
    end

    for (g = 0; g < 9; g++) begin : g_gate
      // Only the selected source passes; every other output is held at zero,
      // which guarantees the one-hot property on the OR-bus.
      assign drv_s[g] = (a_sel == 4'(g)) ? src_s[g] : {WIDTH{1'b0}};
    end
  endgenerate

`ifdef A_BUS_SRC_BYPASS_EN
  assign src_s[8] = (rst_n && imm_ld) ? imm_data : imm_r;
`else
  assign src_s[8] = imm_r;
`endif

  assign drv0    = drv_s[0];
  assign drv1    = drv_s[1];
  assign drv2    = drv_s[2];
  assign drv3    = drv_s[3];
  assign drv4    = drv_s[4];
  assign drv5    = drv_s[5];
  assign drv6    = drv_s[6];
  assign drv7    = drv_s[7];
  assign drv8    = drv_s[8];
  assign sel_err = sel_err_r;

endmodule

// File: tb/tb_a_bus_src_regs.sv
// -----------------------------------------------------------------------------
// tb_a_bus_src_regs
//
// Table-driven bench for a_bus_src_regs. Each vector holds the inputs for one
// cycle plus the expected outputs observed during that cycle (before the edge
// that commits the inputs). Expected outputs are given as "index of the one
// output allowed to be non-zero" plus its value; all other outputs must be 0.
// -----------------------------------------------------------------------------
module tb_a_bus_src_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        imm_ld;
  logic [15:0] imm_data;
  logic [3:0]  a_sel;
  logic [15:0] drv0, drv1, drv2, drv3, drv4, drv5, drv6, drv7, drv8;
  logic        sel_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  a_bus_src_regs #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .imm_ld(imm_ld), .imm_data(imm_data), .a_sel(a_sel),
    .drv0(drv0), .drv1(drv1), .drv2(drv2), .drv3(drv3), .drv4(drv4),
    .drv5(drv5), .drv6(drv6), .drv7(drv7), .drv8(drv8), .sel_err(sel_err)
  );

  typedef struct {
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        imm_ld;
    logic [15:0] imm_data;
    logic [3:0]  a_sel;
    logic        chk;
    logic [3:0]  exp_idx;   // 15 = no output may be non-zero
    logic [15:0] exp_val;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic we, input logic [2:0] wa,
                              input logic [15:0] wd, input logic il, input logic [15:0] id,
                              input logic [3:0] s, input logic c, input logic [3:0] ei,
                              input logic [15:0] ev, input logic ee);
    vec_t v;
    v.rst_n = r; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.imm_ld = il; v.imm_data = id; v.a_sel = s;
    v.chk = c; v.exp_idx = ei; v.exp_val = ev; v.exp_err = ee;
    return v;
  endfunction

  // Compare all nine outputs, their OR, and sel_err against expectations.
  task automatic check_outputs(input string name, input logic [3:0] ei,
                               input logic [15:0] ev, input logic ee);
    logic [8:0][15:0] act, exp;
    logic [15:0]      or_act, or_exp;
    act = {drv8, drv7, drv6, drv5, drv4, drv3, drv2, drv1, drv0};
    or_act = 16'h0000;
    for (int k = 0; k < 9; k++) begin
      exp[k] = (ei == 4'(k)) ? ev : 16'h0000;
      or_act = or_act | act[k];
    end
    or_exp = (ei <= 4'd8) ? ev : 16'h0000;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s drv: got %h required %h", name, act, exp);
    end
    checks++;
    if (or_act !== or_exp) begin
      errors++;
      $display("FAIL %s or_bus: got %h required %h", name, or_act, or_exp);
    end
    checks++;
    if (sel_err !== ee) begin
      errors++;
      $display("FAIL %s sel_err: got %b required %b", name, sel_err, ee);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic il, input logic [15:0] id,
                       input logic [3:0] s);
    rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
    imm_ld = il; imm_data = id; a_sel = s;
  endtask

  logic [15:0] hz_exp;

  initial begin
`ifdef A_BUS_SRC_BYPASS_EN
    hz_exp = 16'h0055;
`else
    hz_exp = 16'h00AA;
`endif

    // Reset held two cycles with a write presented; the write must be dropped.
    vecs.push_back(mk(1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b0, 16'h0000, 4'd3, 1'b0, 4'd3, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b0, 16'h0000, 4'd3, 1'b1, 4'd3, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd3, 1'b1, 4'd3, 16'h0000, 1'b0));
    // Write R_i = 16'h1111*(i+1) while IMM (still zero) is selected.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 1'b1, 3'(i), 16'(16'h1111 * (i + 1)), 1'b0, 16'h0000, 4'd8, 1'b1, 4'd8, 16'h0000, 1'b0));
    // Sweep a_sel 0..7.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'(i), 1'b1, 4'(i), 16'(16'h1111 * (i + 1)), 1'b0));
    // Immediate load and register write in the same cycle.
    vecs.push_back(mk(1'b1, 1'b1, 3'd2, 16'h0042, 1'b1, 16'hBEEF, 4'd0, 1'b1, 4'd0, 16'h1111, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd8, 1'b1, 4'd8, 16'hBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd2, 1'b1, 4'd2, 16'h0042, 1'b0));
    // Same-cycle write/read hazard on R5.
    vecs.push_back(mk(1'b1, 1'b1, 3'd5, 16'h00AA, 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 16'h1111, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 3'd5, 16'h0055, 1'b0, 16'h0000, 4'd5, 1'b1, 4'd5, hz_exp, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd5, 1'b1, 4'd5, 16'h0055, 1'b0));
    // Write to an unselected register leaves the driven output alone.
    vecs.push_back(mk(1'b1, 1'b1, 3'd1, 16'h7777, 1'b0, 16'h0000, 4'd5, 1'b1, 4'd5, 16'h0055, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd1, 1'b1, 4'd1, 16'h7777, 1'b0));
    // Invalid select: outputs zero, sticky error next cycle, cleared by reset.
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'hC, 1'b1, 4'd15, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 16'h1111, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 16'h1111, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 16'h1111, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 16'h0000, 1'b0));
    // Reset mid-write: R7 preloaded, then a write in a reset cycle is dropped
    // and forwarding (if built) must not show it either.
    vecs.push_back(mk(1'b1, 1'b1, 3'd7, 16'h5555, 1'b0, 16'h0000, 4'd0, 1'b1, 4'd0, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 3'd7, 16'h1234, 1'b1, 16'hAAAA, 4'd7, 1'b1, 4'd7, 16'h5555, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd7, 1'b1, 4'd7, 16'h0000, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd8, 1'b1, 4'd8, 16'h0000, 1'b0));

    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd0);
    @(posedge clk); #1;

    // Table: inputs applied just after an edge, outputs sampled mid-cycle.
    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v].rst_n, vecs[v].wr_en, vecs[v].wr_addr, vecs[v].wr_data,
            vecs[v].imm_ld, vecs[v].imm_data, vecs[v].a_sel);
      #3;
      if (vecs[v].chk)
        check_outputs($sformatf("vec%0d", v), vecs[v].exp_idx, vecs[v].exp_val, vecs[v].exp_err);
      @(posedge clk); #1;
    end

    // Hand sequence: every invalid select 9..15 yields all-zero outputs; the
    // first one arms sel_err, which then stays set through the rest.
    for (int s = 9; s < 16; s++) begin
      drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'(s));
      #3;
      check_outputs($sformatf("badsel%0d", s), 4'd15, 16'h0000, (s != 9) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    // Error persists with a valid select, and a write with a_sel held invalid
    // still lands in the register.
    drive(1'b1, 1'b1, 3'd4, 16'hC0DE, 1'b0, 16'h0000, 4'd15);
    #3;
    check_outputs("wr_badsel", 4'd15, 16'h0000, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 4'd4);
    #3;
    check_outputs("rd_after_badsel", 4'd4, 16'hC0DE, 1'b1);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
